// File: rtl/phy_cfg_seq.sv
// rtl/phy_cfg_seq.sv - MDIO PHY configuration sequencer: init-table writes, read-back verify, status polling
module phy_cfg_seq #(
  parameter int unsigned          N_WORDS     = 8,
  parameter logic [N_WORDS*5-1:0] INIT_ADDRS  = {5'd0, 5'd12, 5'd11, 5'd12,
                                                 5'd11, 5'd12, 5'd11, 5'd9},
  parameter logic [N_WORDS*16-1:0] INIT_VALUES = {16'h1340, 16'h0a5a, 16'h8002, 16'h003c,
                                                  16'h4001, 16'h0007, 16'h0de1, 16'h0000},
  parameter int unsigned          MODE_W      = 1,
  parameter int unsigned          MODE_IDX    = 0,
  parameter int unsigned          MODE_LSB    = 9,
  parameter logic [N_WORDS-1:0]   VERIFY_MASK = '0,
  parameter int unsigned          MAX_RETRY   = 3,
  parameter logic [4:0]           STATUS_REG  = 5'd31
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_request_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              mdio_ready_i,
  input  logic [15:0]       mdio_rd_data_i,
  output logic [4:0]        mdio_addr_o,
  output logic [15:0]       mdio_wr_data_o,
  output logic              mdio_rd_req_o,
  output logic              mdio_wr_req_o,
  output logic [1:0]        speed_o,
  output logic              duplex_o,
  output logic              link_o,
  output logic              link_change_o,
  output logic              busy_o,
  output logic              cfg_done_o,
  output logic              cfg_error_o
);

  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [RTY_W-1:0] RETRY_TOP = RTY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    POLL_ISSUE,
    POLL_WAIT,
    WR_ISSUE,
    WR_WAIT,
    VF_ISSUE,
    VF_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               init_pending_q, init_pending_d;
  logic [MODE_W-1:0]  last_mode_q, last_mode_d;
  logic               busy_q, busy_d;
  logic [1:0]         speed_q, speed_d;
  logic               duplex_q, duplex_d;
  logic               link_q, link_d;
  logic               link_seen_q, link_seen_d;
  logic               link_change_q, link_change_d;
  logic               cfg_done_q, cfg_done_d;
  logic               cfg_error_q, cfg_error_d;
  logic               wait_first_q, wait_first_d;

  logic [4:0]         entry_addr;
  logic [15:0]        entry_data;
  logic               wait_exit;
  logic               advance;
  logic               start_run;

  // Current table entry; the mode field is spliced into its entry from the mode captured at run start.
  always_comb begin
    entry_addr = INIT_ADDRS[32'(idx_q) * 32'd5 +: 5];
    entry_data = INIT_VALUES[32'(idx_q) * 32'd16 +: 16];
    if (32'(idx_q) == MODE_IDX) begin
      entry_data[MODE_LSB +: MODE_W] = last_mode_q;
    end
  end

  // Next-state logic: transaction sequencing, verify/retry, restart on a pending init, status capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    retry_d        = retry_q;
    last_mode_d    = last_mode_q;
    busy_d         = busy_q;
    speed_d        = speed_q;
    duplex_d       = duplex_q;
    link_d         = link_q;
    link_seen_d    = link_seen_q;
    link_change_d  = 1'b0;
    cfg_done_d     = 1'b0;
    cfg_error_d    = cfg_error_q;
    wait_first_d   = 1'b0;
    advance        = 1'b0;
    start_run      = 1'b0;
    mdio_rd_req_o  = 1'b0;
    mdio_wr_req_o  = 1'b0;
    init_pending_d = init_pending_q | init_request_i | (mode_i != last_mode_q);
    // The engine needs one cycle to drop ready after a strobe, so the first wait cycle is ignored.
    wait_exit      = !wait_first_q && mdio_ready_i;

    case (state_q)
      POLL_ISSUE: begin
        if (mdio_ready_i && !reset_i) begin
          mdio_rd_req_o = 1'b1;
          wait_first_d  = 1'b1;
          state_d       = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (wait_exit) begin
          speed_d       = mdio_rd_data_i[6:5];
          duplex_d      = mdio_rd_data_i[3];
          link_d        = mdio_rd_data_i[2];
          link_seen_d   = 1'b1;
          link_change_d = link_seen_q && (mdio_rd_data_i[2] != link_q);
          if (init_pending_q) begin
            start_run = 1'b1;
          end else begin
            state_d = POLL_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        if (mdio_ready_i && !reset_i) begin
          mdio_wr_req_o = 1'b1;
          wait_first_d  = 1'b1;
          state_d       = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wait_exit) begin
          if (init_pending_q) begin
            start_run = 1'b1;
          end else if (VERIFY_MASK[idx_q]) begin
            state_d = VF_ISSUE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      VF_ISSUE: begin
        if (mdio_ready_i && !reset_i) begin
          mdio_rd_req_o = 1'b1;
          wait_first_d  = 1'b1;
          state_d       = VF_WAIT;
        end
      end
      VF_WAIT: begin
        if (wait_exit) begin
          if (init_pending_q) begin
            start_run = 1'b1;
          end else if (mdio_rd_data_i == entry_data) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q == RETRY_TOP) begin
            // Out of attempts: flag it and keep going so the rest of the table still lands.
            retry_d     = '0;
            cfg_error_d = 1'b1;
            advance     = 1'b1;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = WR_ISSUE;
          end
        end
      end
      default: begin
        state_d = WR_ISSUE;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        idx_d      = '0;
        busy_d     = 1'b0;
        cfg_done_d = 1'b1;
        state_d    = POLL_ISSUE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = WR_ISSUE;
      end
    end

    // A fresh run (also an aborted one being restarted) re-captures mode and clears the error flag.
    if (start_run) begin
      state_d        = WR_ISSUE;
      idx_d          = '0;
      retry_d        = '0;
      busy_d         = 1'b1;
      cfg_error_d    = 1'b0;
      init_pending_d = 1'b0;
      last_mode_d    = mode_i;
    end
  end

  // Address and data are derived from state and index, both frozen for the whole transaction.
  always_comb begin
    mdio_wr_data_o = entry_data;
    if (state_q == POLL_ISSUE || state_q == POLL_WAIT) begin
      mdio_addr_o = STATUS_REG;
    end else begin
      mdio_addr_o = entry_addr;
    end
  end

  // State registers; reset drops any in-flight transaction and starts the table from entry 0.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= WR_ISSUE;
      idx_q          <= '0;
      retry_q        <= '0;
      init_pending_q <= 1'b0;
      last_mode_q    <= mode_i;
      busy_q         <= 1'b1;
      speed_q        <= 2'b00;
      duplex_q       <= 1'b0;
      link_q         <= 1'b0;
      link_seen_q    <= 1'b0;
      link_change_q  <= 1'b0;
      cfg_done_q     <= 1'b0;
      cfg_error_q    <= 1'b0;
      wait_first_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      retry_q        <= retry_d;
      init_pending_q <= init_pending_d;
      last_mode_q    <= last_mode_d;
      busy_q         <= busy_d;
      speed_q        <= speed_d;
      duplex_q       <= duplex_d;
      link_q         <= link_d;
      link_seen_q    <= link_seen_d;
      link_change_q  <= link_change_d;
      cfg_done_q     <= cfg_done_d;
      cfg_error_q    <= cfg_error_d;
      wait_first_q   <= wait_first_d;
    end
  end

  assign speed_o       = speed_q;
  assign duplex_o      = duplex_q;
  assign link_o        = link_q;
  assign link_change_o = link_change_q;
  assign busy_o        = busy_q;
  assign cfg_done_o    = cfg_done_q;
  assign cfg_error_o   = cfg_error_q;

endmodule

// File: tb/tb_phy_cfg_seq.sv
// tb/tb_phy_cfg_seq.sv - scoreboard bench for phy_cfg_seq with a behavioural MDIO engine
module tb_phy_cfg_seq;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_request;
  logic [0:0]  mode;
  logic        mdio_ready;
  logic [15:0] mdio_rd_data;
  logic [4:0]  mdio_addr;
  logic [15:0] mdio_wr_data;
  logic        mdio_rd_req, mdio_wr_req;
  logic [1:0]  speed;
  logic        duplex, link, link_change, busy, cfg_done, cfg_error;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_seen = 0, rd_seen = 0, done_cnt = 0, lc_cnt = 0, strobe_cnt = 0;
  logic [15:0] status_val;
  int          corrupt_budget;
  logic        hold_ready;
  logic        eng_ready;
  logic [15:0] eng_rd_data;

  logic [4:0]  t_addr [8] = '{5'd9, 5'd11, 5'd12, 5'd11, 5'd12, 5'd11, 5'd12, 5'd0};
  logic [15:0] t_val  [8] = '{16'h0000, 16'h0de1, 16'h0007, 16'h4001,
                              16'h003c, 16'h8002, 16'h0a5a, 16'h1340};

  assign mdio_ready   = eng_ready && !hold_ready;
  assign mdio_rd_data = eng_rd_data;

  always #5 clock = ~clock;

  phy_cfg_seq #(.VERIFY_MASK(8'b0000_0010)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .init_request_i (init_request),
    .mode_i         (mode),
    .mdio_ready_i   (mdio_ready),
    .mdio_rd_data_i (mdio_rd_data),
    .mdio_addr_o    (mdio_addr),
    .mdio_wr_data_o (mdio_wr_data),
    .mdio_rd_req_o  (mdio_rd_req),
    .mdio_wr_req_o  (mdio_wr_req),
    .speed_o        (speed),
    .duplex_o       (duplex),
    .link_o         (link),
    .link_change_o  (link_change),
    .busy_o         (busy),
    .cfg_done_o     (cfg_done),
    .cfg_error_o    (cfg_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int i, input logic m);
    logic [15:0] v;
    v = t_val[i];
    if (i == 0) v[9] = m;
    return v;
  endfunction

  task automatic push(input logic [1:0] k, input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Entry 1 is verified: c bad read-backs cost one extra write/read pair each, up to 3 attempts.
  task automatic push_table(input logic m, input int c, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      int att;
      att = 1;
      if (i == 1) att = (c >= 3) ? 3 : c + 1;
      for (int a = 0; a < att; a++) begin
        push(K_WR, t_addr[i], exp_data(i, m));
        if (i == 1) push(K_RD, t_addr[i], 16'h0000);
      end
    end
    if (with_done) push(K_DONE, 5'd0, 16'h0000);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clock);
    #3;
    check({tag, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse_init();
    @(posedge clock); #2;
    init_request = 1'b1;
    @(posedge clock); #2;
    init_request = 1'b0;
  endtask

  // Monitor on the falling edge, engine response just after the rising edge.
  initial begin
    exp_t        e;
    logic        took, took_rd;
    logic [4:0]  last_addr;
    int          cnt, corrupt_used;
    logic [15:0] mem [32];
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    eng_ready = 1'b1;
    eng_rd_data = 16'h0000;
    cnt = 0;
    corrupt_used = 0;
    last_addr = 5'd0;
    took_rd = 1'b0;
    forever begin
      @(negedge clock);
      took = 1'b0;
      if (!reset) begin
        if (mdio_wr_req || mdio_rd_req) strobe_cnt++;
        if (mdio_wr_req) begin
          check("wr_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_kind", e.kind, K_WR);
            check("wr_addr", mdio_addr, e.addr);
            check("wr_data", mdio_wr_data, e.data);
          end
          mem[mdio_addr] = mdio_wr_data;
          wr_seen++;
          took = 1'b1;
          took_rd = 1'b0;
          last_addr = mdio_addr;
        end
        if (mdio_rd_req) begin
          if (sb.size() != 0 && sb[0].kind == K_RD) begin
            e = sb.pop_front();
            check("vf_addr", mdio_addr, e.addr);
          end else begin
            check("poll_addr", mdio_addr, 31);
          end
          rd_seen++;
          took = 1'b1;
          took_rd = 1'b1;
          last_addr = mdio_addr;
        end
        if (cfg_done) begin
          check("done_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_kind", e.kind, K_DONE);
          end
          done_cnt++;
        end
        if (link_change) lc_cnt++;
      end
      @(posedge clock); #1;
      if (took) begin
        eng_ready = 1'b0;
        cnt = $urandom_range(1, 3);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_ready = 1'b1;
          if (took_rd) begin
            if (last_addr == 5'd31) begin
              eng_rd_data = status_val;
            end else begin
              eng_rd_data = mem[last_addr];
              if (corrupt_used < corrupt_budget) begin
                eng_rd_data = eng_rd_data ^ 16'hffff;
                corrupt_used++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int base, d0, s0, lc0;
    logic [1:0] sp0;
    logic lk0, bz0;
    logic [4:0] ad0;
    reset = 1'b1;
    init_request = 1'b0;
    mode = 1'b1;
    status_val = 16'h0044;
    hold_ready = 1'b0;
    corrupt_budget = 0;

    repeat (3) @(posedge clock);
    #3;
    check("rst_busy", busy, 1);
    check("rst_done", cfg_done, 0);
    check("rst_error", cfg_error, 0);
    check("rst_speed", speed, 0);
    check("rst_link", link, 0);
    check("rst_lc", link_change, 0);
    check("rst_wr_req", mdio_wr_req, 0);

    // Power-up run with mode=1, then status polling.
    push_table(1'b1, 0, 8, 1'b1);
    reset = 1'b0;
    wait_drain("run1", 2000);
    wait_cycles(30);
    check("run1_speed", speed, 2'b10);
    check("run1_link", link, 1);
    check("run1_duplex", duplex, 0);
    check("run1_busy", busy, 0);
    check("run1_lc_cnt", lc_cnt, 0);
    check("run1_done_cnt", done_cnt, 1);
    check("run1_error", cfg_error, 0);

    // Link drops.
    status_val = 16'h0040;
    wait_cycles(40);
    check("drop_link", link, 0);
    check("drop_speed", speed, 2'b10);
    check("drop_lc_cnt", lc_cnt, 1);

    // Mode change while polling.
    push_table(1'b0, 0, 8, 1'b1);
    mode = 1'b0;
    wait_drain("mode", 2000);
    wait_cycles(5);
    check("mode_busy", busy, 0);
    check("mode_done_cnt", done_cnt, 2);

    // Three bad read-backs on the verified entry.
    corrupt_budget = 3;
    push_table(1'b0, 3, 8, 1'b1);
    pulse_init();
    wait_drain("verify", 3000);
    wait_cycles(5);
    check("verify_error", cfg_error, 1);
    check("verify_busy", busy, 0);

    // Reset during an in-flight poll.
    base = rd_seen;
    for (int i = 0; i < 200 && rd_seen == base; i++) begin
      @(posedge clock); #2;
    end
    check("poll_seen", 32'(rd_seen > base), 1);
    reset = 1'b1;
    status_val = 16'h0044;
    repeat (2) @(posedge clock);
    #3;
    check("mid_rst_busy", busy, 1);
    check("mid_rst_error", cfg_error, 0);
    check("mid_rst_link", link, 0);
    check("mid_rst_speed", speed, 0);
    lc0 = lc_cnt;
    d0 = done_cnt;
    push_table(1'b0, 0, 8, 1'b1);
    reset = 1'b0;
    wait_drain("rerun", 2000);
    wait_cycles(30);
    check("rerun_link", link, 1);
    check("rerun_lc_cnt", lc_cnt, lc0);
    check("rerun_done", done_cnt - d0, 1);

    // init_request while entry 4 is in flight.
    push_table(1'b0, 0, 5, 1'b0);
    push_table(1'b0, 0, 8, 1'b1);
    d0 = done_cnt;
    base = wr_seen;
    pulse_init();
    for (int i = 0; i < 2000 && wr_seen < base + 5; i++) begin
      @(posedge clock); #2;
    end
    init_request = 1'b1;
    @(posedge clock); #2;
    init_request = 1'b0;
    check("abort_reached_e4", wr_seen, base + 5);
    wait_drain("abort", 3000);
    wait_cycles(5);
    check("abort_done_cnt", done_cnt - d0, 1);
    check("abort_busy", busy, 0);

    // Engine stalls for 100 cycles.
    @(posedge clock); #2;
    hold_ready = 1'b1;
    s0 = strobe_cnt;
    sp0 = speed;
    lk0 = link;
    bz0 = busy;
    ad0 = mdio_addr;
    repeat (100) @(posedge clock);
    #3;
    check("hold_strobes", strobe_cnt, s0);
    check("hold_speed", speed, sp0);
    check("hold_link", link, lk0);
    check("hold_busy", busy, bz0);
    check("hold_addr", mdio_addr, ad0);
    hold_ready = 1'b0;
    wait_cycles(30);
    check("hold_resumed", 32'(strobe_cnt > s0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
